// File: rtl/nw_job_scheduler.sv
// rtl/nw_job_scheduler.sv - round-robin job scheduler feeding one alignment grid
module nw_job_scheduler #(
    parameter int LENGTH       = 10,
    parameter int CWIDTH       = 2,
    parameter int SWIDTH       = 16,
    parameter int NREQ         = 4,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    localparam int SLEN        = LENGTH * CWIDTH,
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*SLEN-1:0]   req_s1,
    input  logic [NREQ*SLEN-1:0]   req_s2,
    output logic                   grid_reset,
    output logic [SLEN-1:0]        grid_s1,
    output logic [SLEN-1:0]        grid_s2,
    input  logic [SWIDTH-1:0]      grid_score,
    input  logic                   grid_valid,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [SWIDTH-1:0]      rsp_score,
    output logic                   rsp_timeout,
    output logic                   busy
);
    localparam int CMAX = (TIMEOUT > CLEAR_CYCLES) ? TIMEOUT : CLEAR_CYCLES;
    localparam int CNTW = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] counter;
    logic [IDW-1:0]  winner;
    logic [IDW:0]    cand;
    logic            found;
    logic            accept;
    logic            clear_done;
    logic            run_hit;
    logic            run_expire;

    // Search from rr_ptr upward, wrapping past NREQ-1 back to 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    assign accept     = reset && (state == IDLE) && found;
    assign clear_done = (counter == CNTW'(CLEAR_CYCLES - 1));
    assign run_hit    = (state == RUN) && grid_valid;
    assign run_expire = (state == RUN) && !grid_valid && (counter == CNTW'(TIMEOUT - 1));

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (found) state_nxt = CLEAR;
            CLEAR: if (clear_done) state_nxt = RUN;
            RUN:   if (run_hit || run_expire) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One counter serves both the CLEAR hold and the RUN timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter <= '0;
        end else if (accept) begin
            counter <= '0;
        end else if (state == CLEAR) begin
            counter <= clear_done ? '0 : counter + 1'b1;
        end else if (state == RUN) begin
            counter <= counter + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr      <= '0;
            grid_s1     <= '0;
            grid_s2     <= '0;
            rsp_id      <= '0;
            rsp_score   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr  <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                grid_s1 <= req_s1[winner*SLEN +: SLEN];
                grid_s2 <= req_s2[winner*SLEN +: SLEN];
                rsp_id  <= winner;
            end
            if (run_hit) begin
                rsp_score   <= grid_score;
                rsp_timeout <= 1'b0;
            end else if (run_expire) begin
                rsp_score   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign grid_reset = !reset || (state == IDLE) || (state == CLEAR);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_nw_job_scheduler.sv
// tb/tb_nw_job_scheduler.sv - randomized self-checking bench for nw_job_scheduler
module tb_nw_job_scheduler;
    localparam int LENGTH  = 4;
    localparam int CWIDTH  = 2;
    localparam int SWIDTH  = 16;
    localparam int NREQ    = 4;
    localparam int CLEAR   = 2;
    localparam int TIMEOUT = 16;
    localparam int SLEN    = LENGTH * CWIDTH;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SLEN-1:0] req_s1 = '0;
    logic [NREQ*SLEN-1:0] req_s2 = '0;
    logic                 grid_reset;
    logic [SLEN-1:0]      grid_s1, grid_s2;
    logic [SWIDTH-1:0]    grid_score = '0;
    logic                 grid_valid = 1'b0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [1:0]           rsp_id;
    logic [SWIDTH-1:0]    rsp_score;
    logic                 rsp_timeout;
    logic                 busy;

    int n_checks = 0;
    int n_pass   = 0;
    int rr       = 0;
    int gcnt     = 0;
    int stub_delay = 0;
    logic [SWIDTH-1:0] stub_score = '0;

    nw_job_scheduler #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .NREQ(NREQ),
        .CLEAR_CYCLES(CLEAR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_s1(req_s1), .req_s2(req_s2), .grid_reset(grid_reset),
        .grid_s1(grid_s1), .grid_s2(grid_s2), .grid_score(grid_score),
        .grid_valid(grid_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_score(rsp_score), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to the next falling edge and let the grid stub react to what it sees.
    task automatic tick();
        @(negedge clk);
        grid_score = stub_score;
        if (grid_reset) begin
            gcnt = 0;
            grid_valid = 1'b0;
        end else begin
            grid_valid = (gcnt == stub_delay);
            gcnt++;
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic run_job(input logic [NREQ-1:0] mask, input int delay,
                           input logic [SWIDTH-1:0] score, input int hold);
        int w, n, exp_lat;
        logic seen, exp_to;
        logic [SLEN-1:0] e1, e2;
        logic [SWIDTH-1:0] exp_score;
        stub_delay = delay;
        stub_score = score;
        req_valid = mask;
        req_s1 = $urandom;
        req_s2 = $urandom;
        #1;
        w = pick(mask, rr);
        check("grant", req_ready, 64'(4'(1) << w));
        e1 = req_s1[w*SLEN +: SLEN];
        e2 = req_s2[w*SLEN +: SLEN];
        rr = (w + 1) % NREQ;
        exp_to = (delay >= TIMEOUT);
        exp_lat = CLEAR + 2 + (exp_to ? TIMEOUT - 1 : delay);
        exp_score = exp_to ? '0 : score;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                check("grid_reset_phase", grid_reset, 64'(n <= CLEAR));
                check("ready_while_busy", req_ready, 0);
                check("grid_s1_stable", grid_s1, e1);
            end
        end
        check("latency", n, exp_lat);
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, w);
            check("rsp_score", rsp_score, exp_score);
            check("rsp_timeout", rsp_timeout, exp_to);
            check("ready_in_resp", req_ready, 0);
            check("grid_s2_stable", grid_s2, e2);
            if (h == hold) begin
                rsp_ready = 1'b1;
                req_valid = '0;
            end
            tick();
        end
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_grid_reset", grid_reset, 1);
    endtask

    initial begin
        req_valid = '1;
        tick();
        tick();
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_grid_reset", grid_reset, 1);
        check("rst_grid_s1", grid_s1, 0);
        check("rst_rsp_score", rsp_score, 0);
        reset = 1'b1;
        req_valid = '0;
        tick();

        for (int j = 0; j < 5; j++)
            run_job('1, 1 + j, SWIDTH'($urandom), 0);
        run_job(4'b0001, 100, 16'h1234, 0);
        run_job(4'b0110, TIMEOUT - 1, 16'hfffc, 0);
        run_job(4'b1000, TIMEOUT, 16'h0042, 0);
        run_job(4'b1010, 3, 16'h0004, 5);

        for (int j = 0; j < 25; j++)
            run_job(NREQ'($urandom_range(1, 15)), $urandom_range(0, 20),
                    SWIDTH'($urandom), $urandom_range(0, 4));

        // Abort a job mid-RUN; the scheduler must return to IDLE with rr_ptr cleared.
        stub_delay = 1000;
        req_valid = 4'b0100;
        req_s1 = $urandom;
        tick();
        for (int k = 0; k < CLEAR + 3; k++) tick();
        check("pre_abort_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_ready", req_ready, 0);
        check("abort_grid_reset", grid_reset, 1);
        tick();
        reset = 1'b1;
        req_valid = '0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_grid_reset_idle", grid_reset, 1);
        check("abort_grid_s1", grid_s1, 0);
        rr = 0;
        tick();
        run_job('1, 2, 16'h0777, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nw_job_scheduler.md
NW_JOB_SCHEDULER -- requirements
Module: nw_job_scheduler

Interface
REQ-001 Parameter LENGTH, default 10: characters per string.
REQ-002 Parameter CWIDTH, default 2: bits per character.
REQ-003 Parameter SWIDTH, default 16: bits per score.
REQ-004 Parameter NREQ, default 4: number of requesters (2..16).
REQ-005 Parameter CLEAR_CYCLES, default 2: cycles grid_reset is held per job (>=1).
REQ-006 Parameter TIMEOUT, default 1024: maximum RUN cycles before a job is abandoned (>=2).
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-low.
REQ-009 req_valid  in  NREQ  per-requester job request.
REQ-010 req_ready  out  NREQ  one-hot grant; a job is accepted in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-011 req_s1, req_s2  in  NREQ*LENGTH*CWIDTH  packed strings; requester i occupies slice [i*LENGTH*CWIDTH +: LENGTH*CWIDTH].
REQ-012 grid_reset  out  1  active-high reset to the alignment grid.
REQ-013 grid_s1, grid_s2  out  LENGTH*CWIDTH  latched strings driven to the grid.
REQ-014 grid_score  in  SWIDTH  signed grid result.
REQ-015 grid_valid  in  1  grid completion flag.
REQ-016 rsp_valid  out  1; rsp_ready  in  1: response handshake.
REQ-017 rsp_id  out  clog2(NREQ) (min 1)  index of the requester served.
REQ-018 rsp_score  out  SWIDTH  signed score.
REQ-019 rsp_timeout  out  1  job abandoned at TIMEOUT.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, CLEAR, RUN, RESP.
REQ-022 IDLE: if any req_valid, the winner is the first asserted index at or after rr_ptr (wrapping NREQ-1 -> 0); req_ready[winner]=1 combinationally in that cycle only; strings and id are latched; rr_ptr becomes (winner+1) mod NREQ; next state CLEAR.
REQ-023 req_ready is 0 in every state except IDLE; a request pending in another state waits.
REQ-024 CLEAR: grid_reset=1 for exactly CLEAR_CYCLES cycles, then RUN.
REQ-025 RUN: grid_reset=0; cycle counter starts at 0 on entry and increments each cycle.
REQ-026 RUN, grid_valid=1: latch rsp_score=grid_score, rsp_timeout=0, go RESP.
REQ-027 RUN, counter==TIMEOUT-1 and grid_valid=0: rsp_score=0, rsp_timeout=1, go RESP.
REQ-028 grid_valid and timeout in the same cycle: grid_valid wins (rsp_timeout=0).
REQ-029 RESP: rsp_valid=1; rsp_id/rsp_score/rsp_timeout are held stable until the handshake completes; grid_reset=0 (grid result retained).
REQ-030 RESP with rsp_ready=1: handshake completes that cycle; next state IDLE, rsp_valid=0 next cycle.
REQ-031 Minimum job latency from acceptance to rsp_valid: CLEAR_CYCLES + 1 + (grid cycles to valid).
REQ-032 grid_s1/grid_s2 change only on acceptance; they are stable through CLEAR, RUN and RESP.
REQ-033 Counter is wide enough for TIMEOUT without wrap.

Reset
REQ-034 When reset=0 at a clock edge: state=IDLE, rr_ptr=0, counter=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_score=0, rsp_timeout=0, busy=0, grid_s1=grid_s2=0.
REQ-035 grid_reset=1 while reset=0 and in IDLE; goes to 0 only in RUN/RESP.
REQ-036 Reset asserted mid-job (any state) abandons the job with no response; no grant on the reset cycle.

Verification
REQ-037 LENGTH=4, CWIDTH=2, real grid, requester 0 sends s1=s2=8'b00011011 -> one grant to 0, rsp_id=0, rsp_score=4, rsp_timeout=0.
REQ-038 NREQ=4, all req_valid held 1, rsp_ready=1 -> grant order 0,1,2,3,0 with rsp_id matching, never two bits of req_ready set.
REQ-039 Grid stub with grid_valid stuck 0, TIMEOUT=16 -> rsp_valid exactly 16 cycles after RUN entry, rsp_timeout=1, rsp_score=0.
REQ-040 Stub asserts grid_valid on cycle 15 of RUN with TIMEOUT=16 -> rsp_timeout=0, rsp_score=stub value.
REQ-041 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-042 reset=0 pulsed during RUN -> next cycle IDLE, rsp_valid=0, grid_reset=1, rr_ptr=0; a subsequent request completes normally.
